// File: rtl/usb_out_receiver.sv
// USB full-speed OUT endpoint receiver: buffers OUT data packets in a 16x8 FIFO and
// exposes only ACKed, complete packets to user logic; bad packets are rolled back.
module usb_out_receiver #(
  parameter logic [3:0]  ENDPOINT = 4'd1,
  parameter int unsigned MAX_PKT  = 8
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       usb_rst,
  input  logic       transaction_active,
  input  logic [3:0] endpoint,
  input  logic       direction_in,
  input  logic       setup,
  input  logic       data_strobe,
  input  logic       success,
  input  logic [7:0] usb_din,
  output logic       out_ready,
  output logic [7:0] dout,
  output logic       dout_v,
  input  logic       dout_rdy,
  output logic       overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] SKIP = 2'd2;

  localparam int unsigned CNT_W = $clog2(MAX_PKT + 2);

  logic [1:0]       state_q, state_d;
  logic [4:0]       rd_ptr_q;
  logic [4:0]       wr_ptr_q;
  logic [4:0]       wr_commit_q;
  logic             bad_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic             out_ready_q;
  logic [7:0]       mem [16];

  logic       do_rst;
  logic [4:0] wr_used;
  logic [4:0] committed;
  logic [5:0] free_space;
  logic       fifo_full;
  logic       pkt_full;
  logic       rx_start;
  logic       rx_strobe;
  logic       rx_end;
  logic       wr_en;
  logic       pop;
  logic       out_ready_d;

  assign do_rst = rst | usb_rst;

  // Speculative fill includes the uncommitted bytes of the packet in flight.
  assign wr_used    = wr_ptr_q - rd_ptr_q;
  assign committed  = wr_commit_q - rd_ptr_q;
  assign free_space = 6'd16 - {1'b0, committed};
  assign fifo_full  = (wr_used == 5'd16);
  assign pkt_full   = (pkt_cnt_q == CNT_W'(MAX_PKT));

  assign rx_start  = (state_q == IDLE) && (state_d == RECV);
  assign rx_strobe = (state_q == RECV) && transaction_active && data_strobe;
  assign rx_end    = (state_q == RECV) && !transaction_active;
  assign wr_en     = rx_strobe && !fifo_full && !pkt_full && !do_rst;

  assign dout_v      = (wr_commit_q != rd_ptr_q);
  assign dout        = mem[rd_ptr_q[3:0]];
  assign pop         = dout_v && dout_rdy;
  assign out_ready_d = ({26'd0, free_space} >= MAX_PKT);
  assign out_ready   = out_ready_q;
  assign overflow    = rx_end && bad_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (transaction_active) begin
          if (endpoint == ENDPOINT && !direction_in && !setup) state_d = RECV;
          else state_d = SKIP;
        end
      end
      RECV: if (!transaction_active) state_d = IDLE;
      SKIP: if (!transaction_active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk48) begin
    if (do_rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= 5'd0;
      wr_ptr_q    <= 5'd0;
      wr_commit_q <= 5'd0;
      bad_q       <= 1'b0;
      pkt_cnt_q   <= '0;
      out_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_ready_q <= out_ready_d;
      if (pop) rd_ptr_q <= rd_ptr_q + 5'd1;

      if (rx_start) begin
        wr_ptr_q  <= wr_commit_q;
        bad_q     <= 1'b0;
        pkt_cnt_q <= '0;
      end else if (rx_end) begin
        if (success && !bad_q) wr_commit_q <= wr_ptr_q;
        else wr_ptr_q <= wr_commit_q;
      end else if (rx_strobe) begin
        if (wr_en) begin
          wr_ptr_q  <= wr_ptr_q + 5'd1;
          pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
        end else begin
          bad_q <= 1'b1;
        end
      end
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk48) begin
    if (wr_en) mem[wr_ptr_q[3:0]] <= usb_din;
  end

endmodule

// File: tb/tb_usb_out_receiver.sv
// Directed bench for usb_out_receiver: a vector table for a basic OUT transfer plus
// hand-written sequences for rollback, filtering, overflow and reset corner cases.
module tb_usb_out_receiver;

  logic       clk48 = 1'b0;
  logic       rst = 1'b1;
  logic       usb_rst = 1'b0;
  logic       transaction_active = 1'b0;
  logic [3:0] endpoint = 4'd0;
  logic       direction_in = 1'b0;
  logic       setup = 1'b0;
  logic       data_strobe = 1'b0;
  logic       success = 1'b0;
  logic [7:0] usb_din = 8'd0;
  logic       out_ready;
  logic [7:0] dout;
  logic       dout_v;
  logic       dout_rdy = 1'b0;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;

  usb_out_receiver #(
    .ENDPOINT(4'd1),
    .MAX_PKT (8)
  ) dut (
    .clk48             (clk48),
    .rst               (rst),
    .usb_rst           (usb_rst),
    .transaction_active(transaction_active),
    .endpoint          (endpoint),
    .direction_in      (direction_in),
    .setup             (setup),
    .data_strobe       (data_strobe),
    .success           (success),
    .usb_din           (usb_din),
    .out_ready         (out_ready),
    .dout              (dout),
    .dout_v            (dout_v),
    .dout_rdy          (dout_rdy),
    .overflow          (overflow)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    logic       rst;
    logic       ta;
    logic [3:0] ep;
    logic       stb;
    logic [7:0] din;
    logic       succ;
    logic       rdy;
    logic       chk;
    logic       ordy;
    logic       dv;
    logic [7:0] dout;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk48);
    @(negedge clk48);
  endtask

  task automatic xact(input logic [3:0] ep, input logic dir, input logic stp, input int n,
                      input logic [7:0] first, input logic ok);
    ovf_cnt = 0;
    transaction_active = 1'b1;
    endpoint = ep;
    direction_in = dir;
    setup = stp;
    #1 ovf_cnt += int'(overflow);
    tick();
    for (int i = 0; i < n; i++) begin
      data_strobe = 1'b1;
      usb_din = first + 8'(i);
      #1 ovf_cnt += int'(overflow);
      tick();
    end
    data_strobe = 1'b0;
    transaction_active = 1'b0;
    success = ok;
    #1 ovf_cnt += int'(overflow);
    tick();
    success = 1'b0;
    direction_in = 1'b0;
    setup = 1'b0;
    #1 ovf_cnt += int'(overflow);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] val);
    chk({name, " dout_v"}, 32'(dout_v), 32'd1);
    chk({name, " dout"}, 32'(dout), 32'(val));
    dout_rdy = 1'b1;
    tick();
    dout_rdy = 1'b0;
    #1;
  endtask

  initial begin
    //           rst   ta    ep    stb   din    succ  rdy   chk   ordy  dv    dout   ovf
    vecs[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'd1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'd1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    @(negedge clk48);
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst;
      transaction_active = vecs[i].ta;
      endpoint = vecs[i].ep;
      data_strobe = vecs[i].stb;
      usb_din = vecs[i].din;
      success = vecs[i].succ;
      dout_rdy = vecs[i].rdy;
      #1;
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d out_ready", i), 32'(out_ready), 32'(vecs[i].ordy));
        chk($sformatf("vec%0d dout_v", i), 32'(dout_v), 32'(vecs[i].dv));
        chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
        if (vecs[i].dv) chk($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].dout));
      end
      @(negedge clk48);
    end
    dout_rdy = 1'b0;

    // Failed OUT is rolled back; the next good packet is what the user sees first.
    xact(4'd1, 1'b0, 1'b0, 4, 8'hE0, 1'b0);
    chk("nak ovf", 32'(ovf_cnt), 32'd0);
    chk("nak dout_v", 32'(dout_v), 32'd0);
    xact(4'd1, 1'b0, 1'b0, 1, 8'hA5, 1'b1);
    pop_expect("after nak", 8'hA5);
    chk("after nak empty", 32'(dout_v), 32'd0);

    // Foreign endpoint, IN and SETUP transactions are ignored.
    xact(4'd2, 1'b0, 1'b0, 3, 8'h01, 1'b1);
    chk("ep2 dout_v", 32'(dout_v), 32'd0);
    xact(4'd1, 1'b1, 1'b0, 3, 8'h02, 1'b1);
    chk("in dout_v", 32'(dout_v), 32'd0);
    xact(4'd1, 1'b0, 1'b1, 3, 8'h03, 1'b1);
    chk("setup dout_v", 32'(dout_v), 32'd0);
    chk("ignored ovf", 32'(ovf_cnt), 32'd0);

    // Zero-length OUT commits nothing.
    xact(4'd1, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    chk("zlp dout_v", 32'(dout_v), 32'd0);

    // Fill to 16 with the reader stalled, then overflow a third packet.
    xact(4'd1, 1'b0, 1'b0, 8, 8'h40, 1'b1);
    tick();
    chk("half out_ready", 32'(out_ready), 32'd1);
    xact(4'd1, 1'b0, 1'b0, 8, 8'h50, 1'b1);
    tick();
    chk("full out_ready", 32'(out_ready), 32'd0);
    chk("full dout", 32'(dout), 32'h40);
    xact(4'd1, 1'b0, 1'b0, 8, 8'h60, 1'b1);
    chk("full ovf pulses", 32'(ovf_cnt), 32'd1);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("full pop%0d", i), 8'h40 + 8'(i));
    for (int i = 0; i < 8; i++) pop_expect($sformatf("full pop%0d", i + 8), 8'h50 + 8'(i));
    chk("full drained", 32'(dout_v), 32'd0);
    tick();
    chk("drained out_ready", 32'(out_ready), 32'd1);

    // Oversize packet is discarded even though ACKed.
    xact(4'd1, 1'b0, 1'b0, 9, 8'h70, 1'b1);
    chk("long ovf pulses", 32'(ovf_cnt), 32'd1);
    chk("long dout_v", 32'(dout_v), 32'd0);
    xact(4'd1, 1'b0, 1'b0, 1, 8'h81, 1'b1);
    pop_expect("after long", 8'h81);

    // Reset mid-packet drops committed and partial data alike.
    xact(4'd1, 1'b0, 1'b0, 1, 8'h99, 1'b1);
    chk("pre-rst dout_v", 32'(dout_v), 32'd1);
    transaction_active = 1'b1;
    endpoint = 4'd1;
    tick();
    for (int i = 0; i < 3; i++) begin
      data_strobe = 1'b1;
      usb_din = 8'hC0 + 8'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    transaction_active = 1'b0;
    data_strobe = 1'b0;
    #1;
    chk("rst out_ready", 32'(out_ready), 32'd1);
    chk("rst dout_v", 32'(dout_v), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    xact(4'd1, 1'b0, 1'b0, 1, 8'h5A, 1'b1);
    pop_expect("after rst", 8'h5A);
    chk("after rst alone", 32'(dout_v), 32'd0);

    // Bus reset behaves like rst.
    xact(4'd1, 1'b0, 1'b0, 2, 8'h31, 1'b1);
    usb_rst = 1'b1;
    tick();
    usb_rst = 1'b0;
    #1;
    chk("usb_rst dout_v", 32'(dout_v), 32'd0);
    chk("usb_rst out_ready", 32'(out_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_out_receiver.md
USB_OUT_RECEIVER -- requirements
Module: usb_out_receiver

Interface
REQ-001 SHALL have parameter ENDPOINT, default 4'd1: OUT endpoint number this block accepts.
REQ-002 SHALL have parameter MAX_PKT, default 8: max bytes per OUT data packet; FIFO depth fixed at 16.
REQ-003 SHALL have port clk48  in  1: 48 MHz clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port usb_rst  in  1: bus reset from USB core; same effect as rst.
REQ-006 SHALL have port transaction_active  in  1: core transaction in progress.
REQ-007 SHALL have port endpoint  in  4: endpoint of current transaction.
REQ-008 SHALL have port direction_in  in  1: 1 = IN transaction (ignored by this block).
REQ-009 SHALL have port setup  in  1: 1 = SETUP transaction (ignored by this block).
REQ-010 SHALL have port data_strobe  in  1: one-cycle pulse, usb_din valid.
REQ-011 SHALL have port success  in  1: transaction ACKed; valid on first cycle transaction_active is low.
REQ-012 SHALL have port usb_din  in  8: OUT data byte from core.
REQ-013 SHALL have port out_ready  out  1: to core; 1 = room for a full packet, else core NAKs.
REQ-014 SHALL have port dout  out  8: head-of-FIFO byte to user logic.
REQ-015 SHALL have port dout_v  out  1: dout valid.
REQ-016 SHALL have port dout_rdy  in  1: user accepts byte.
REQ-017 SHALL have port overflow  out  1: one-cycle pulse, packet discarded for overflow.

Function
REQ-018 SHALL implement 16x8 FIFO with 5-bit pointers: rd_ptr, wr_ptr (speculative), wr_commit.
REQ-019 SHALL implement FSM states IDLE, RECV, SKIP.
REQ-020 IDLE->RECV when transaction_active=1, endpoint==ENDPOINT, direction_in=0, setup=0; IDLE->SKIP when transaction_active=1 otherwise.
REQ-021 On entering RECV, wr_ptr SHALL equal wr_commit; bad flag cleared.
REQ-022 In RECV, each data_strobe SHALL write usb_din at wr_ptr[3:0] and increment wr_ptr, if wr_ptr-rd_ptr<16.
REQ-023 In RECV, data_strobe with wr_ptr-rd_ptr==16 SHALL drop the byte and set bad.
REQ-024 In RECV, bytes beyond MAX_PKT in one transaction SHALL be dropped and set bad.
REQ-025 RECV->IDLE on first cycle transaction_active=0: if success=1 and bad=0, wr_commit<=wr_ptr; else wr_ptr<=wr_commit.
REQ-026 Overflow SHALL pulse for exactly one cycle, on the RECV->IDLE cycle, when bad=1.
REQ-027 SKIP->IDLE when transaction_active=0; no FIFO writes in SKIP or IDLE.
REQ-028 User side SHALL see committed data only: dout_v = (wr_commit != rd_ptr).
REQ-029 dout SHALL be mem[rd_ptr[3:0]] combinationally; rd_ptr increments when dout_v && dout_rdy.
REQ-030 out_ready SHALL be registered, = (16 - (wr_commit - rd_ptr)) >= MAX_PKT, updated every cycle.
REQ-031 Read and commit in same cycle SHALL both take effect; pointer arithmetic modulo 32.
REQ-032 Reads SHALL continue during RECV; freed space is usable by the in-progress packet.
REQ-033 Zero-length successful OUT SHALL commit nothing and leave dout_v unchanged.

Reset
REQ-034 On rst or usb_rst: pointers 0, state IDLE, bad 0, overflow 0, dout_v 0, out_ready 1.
REQ-035 Reset mid-RECV SHALL discard the partial packet; FIFO memory contents not cleared.
REQ-036 Reset SHALL take effect at the next clk48 edge, overriding all other updates that cycle.

Verification
REQ-037 OUT to EP1, bytes 0x11,0x22,0x33, success=1, dout_rdy=1 -> dout 0x11,0x22,0x33 in order, dout_v only after transaction_active falls.
REQ-038 OUT to EP1, 4 bytes, success=0 -> dout_v stays 0, wr_ptr returns to wr_commit, next good packet 0xA5 read first.
REQ-039 OUT to EP2 and IN to EP1 with strobes -> no FIFO writes, dout_v 0.
REQ-040 dout_rdy=0, two good 8-byte packets -> out_ready 0 after second commit; third packet bytes drop, overflow pulses once, count stays 16.
REQ-041 9-byte packet with success=1 -> discarded, overflow pulse, dout_v 0.
REQ-042 rst asserted after 3 strobes of a packet -> all outputs at reset values next cycle, following packet 0x5A delivered alone.
